readout_sequencer: RTL and testbench

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/readout_pkg.sv | 15 +
 rtl/readout_checksum.sv | 21 ++
 rtl/readout_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_readout_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared state encoding and byte constants for the readout sequencer
package readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

    localparam logic [7:0] CHECKSUM_SEED = 8'h00;
    localparam logic [7:0] OOB_BYTE      = 8'h00;

endpackage

// File: rtl/readout_checksum.sv
// rtl/readout_checksum.sv - XOR accumulator over the bytes of one scan
module readout_checksum
    import readout_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] byte_in,
    output logic [7:0] sum
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            sum <= CHECKSUM_SEED;
        end else if (enable) begin
            sum <= sum ^ byte_in;
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - scans/reads the decoded byte store onto a valid/ready stream; READOUT_CHECKSUM_EN appends an XOR byte
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int NUM_BYTES = 4,
    parameter int ADDR_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_valid,
    input  logic              transmission_begin,
    output logic [ADDR_W-1:0] mux_address,
    input  logic [7:0]        mux_data,
    input  logic              manual_req,
    input  logic [ADDR_W-1:0] manual_address,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(NUM_BYTES - 1);
    localparam logic [ADDR_W:0]   NUM_BYTES_EXT = (ADDR_W + 1)'(NUM_BYTES);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        byte_q;
    logic              fv_q;
    logic              manual_q;
    logic              overrun_q;

    logic              fv_rise;
    logic              last_addr;
    logic              addr_oob;
    logic              start_scan;
    logic              start_manual;
    logic              advance;
    logic              load_byte;
    logic              abort;
    logic [7:0]        capture_value;

`ifdef READOUT_CHECKSUM_EN
    logic              csum_phase_q;
    logic              enter_csum;
    logic [7:0]        csum;

    readout_checksum u_checksum (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_scan),
        .enable  (load_byte && !csum_phase_q && !manual_q),
        .byte_in (capture_value),
        .sum     (csum)
    );
`endif

    assign fv_rise   = frame_valid && !fv_q;
    assign last_addr = (addr_q == LAST_ADDR);
    assign addr_oob  = ({1'b0, addr_q} >= NUM_BYTES_EXT);

    always_comb begin
        capture_value = addr_oob ? OOB_BYTE : mux_data;
`ifdef READOUT_CHECKSUM_EN
        if (csum_phase_q) begin
            capture_value = csum;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_scan   = 1'b0;
        start_manual = 1'b0;
        advance      = 1'b0;
        load_byte    = 1'b0;
        abort        = 1'b0;
`ifdef READOUT_CHECKSUM_EN
        enter_csum   = 1'b0;
`endif
        // A new transmission overwrites the store, so any scan in flight is stale.
        if (transmission_begin && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            abort   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fv_rise) begin
                        state_d    = ST_SETUP;
                        start_scan = 1'b1;
                    end else if (manual_req) begin
                        state_d      = ST_SETUP;
                        start_manual = 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_d   = ST_PRESENT;
                    load_byte = 1'b1;
                end
                ST_PRESENT: begin
                    if (byte_ready) begin
                        if (manual_q) begin
                            state_d = ST_IDLE;
                        end else if (!last_addr) begin
                            state_d = ST_SETUP;
                            advance = 1'b1;
`ifdef READOUT_CHECKSUM_EN
                        end else if (!csum_phase_q) begin
                            state_d    = ST_CAPTURE;
                            enter_csum = 1'b1;
`endif
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            byte_q    <= 8'h00;
            fv_q      <= 1'b0;
            manual_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            fv_q <= frame_valid;
            if (abort) begin
                overrun_q <= 1'b1;
            end
            if (start_scan) begin
                addr_q   <= '0;
                manual_q <= 1'b0;
            end else if (start_manual) begin
                addr_q   <= manual_address;
                manual_q <= 1'b1;
            end else if (advance && !last_addr) begin
                addr_q <= addr_q + 1'b1;
            end
            if (load_byte) begin
                byte_q <= capture_value;
            end
        end
    end

`ifdef READOUT_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset || start_scan) begin
            csum_phase_q <= 1'b0;
        end else if (enter_csum) begin
            csum_phase_q <= 1'b1;
        end
    end
`endif

    assign mux_address = addr_q;
    assign byte_out    = byte_q;
    assign byte_valid  = (state_q == ST_PRESENT);
    assign frame_done  = (state_q == ST_DONE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// tb/tb_readout_sequencer.sv - directed and randomized checks of readout_sequencer against a byte-stream model
module tb_readout_sequencer;

    localparam int NUM_BYTES = 4;
    localparam int ADDR_W    = 4;
`ifdef READOUT_CHECKSUM_EN
    localparam int SCAN_LEN  = NUM_BYTES + 1;
`else
    localparam int SCAN_LEN  = NUM_BYTES;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              frame_valid = 1'b0;
    logic              transmission_begin = 1'b0;
    logic              manual_req = 1'b0;
    logic [ADDR_W-1:0] manual_address = '0;
    logic              byte_ready = 1'b0;
    logic [ADDR_W-1:0] mux_address;
    logic [7:0]        mux_data;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              frame_done;
    logic              overrun;

    logic [7:0] store [16];
    logic [7:0] got [$];
    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    assign mux_data = store[mux_address];

    readout_sequencer #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .frame_valid        (frame_valid),
        .transmission_begin (transmission_begin),
        .mux_address        (mux_address),
        .mux_data           (mux_data),
        .manual_req         (manual_req),
        .manual_address     (manual_address),
        .byte_out           (byte_out),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .frame_done         (frame_done),
        .overrun            (overrun)
    );

    // Transfers and frame_done pulses are observed mid-cycle, between active edges.
    always @(negedge clock) begin
        if (!reset && byte_valid && byte_ready) got.push_back(byte_out);
        if (!reset && frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_bytes(input string tag, input int n, input bit rnd);
        int k = 0;
        while (got.size() < n && k < 400) begin
            byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        byte_ready = 1'b0;
        check({tag, "_timeout"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!byte_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_valid_timeout"}, 32'(byte_valid), 32'd1);
    endtask

    task automatic expect_scan(input string tag, input int base);
        logic [7:0] x;
        x = 8'h00;
        check({tag, "_len"}, 32'(got.size()), 32'(base + SCAN_LEN));
        for (int i = 0; i < NUM_BYTES; i++) begin
            check({tag, "_byte"}, 32'(got[base + i]), 32'(store[i]));
            x = x ^ store[i];
        end
`ifdef READOUT_CHECKSUM_EN
        check({tag, "_csum"}, 32'(got[base + NUM_BYTES]), 32'(x));
`endif
    endtask

    task automatic run_scan(input string tag, input bit rnd);
        int base;
        int d0;
        base = got.size();
        d0   = done_cnt;
        frame_valid = 1'b1;
        wait_bytes(tag, base + SCAN_LEN, rnd);
        repeat (3) tick();
        frame_valid = 1'b0;
        tick();
        expect_scan(tag, base);
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic manual_read(input string tag, input int addr, input bit rnd);
        int base;
        int d0;
        base = got.size();
        d0   = done_cnt;
        manual_address = ADDR_W'(addr);
        manual_req = 1'b1;
        tick();
        manual_req = 1'b0;
        wait_bytes(tag, base + 1, rnd);
        repeat (4) tick();
        check({tag, "_len"}, 32'(got.size()), 32'(base + 1));
        check({tag, "_byte"}, 32'(got[base]), (addr < NUM_BYTES) ? 32'(store[addr]) : 32'd0);
        check({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
    endtask

    initial begin
        int base;
        int d0;
        int k;
        for (int i = 0; i < 16; i++) store[i] = 8'h00;

        reset = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_out", 32'(byte_out), 32'd0);
        check("rst_addr", 32'(mux_address), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_valid", 32'(byte_valid), 32'd0);

        store[0] = 8'h11; store[1] = 8'h22; store[2] = 8'h33; store[3] = 8'h44;

        // Scan with latency: rising edge sampled at T, address at T+1, valid at T+3.
        base = got.size();
        d0   = done_cnt;
        byte_ready  = 1'b1;
        frame_valid = 1'b1;
        tick();
        check("lat_addr_t1", 32'(mux_address), 32'd0);
        check("lat_valid_t1", 32'(byte_valid), 32'd0);
        tick();
        check("lat_valid_t2", 32'(byte_valid), 32'd0);
        tick();
        check("lat_valid_t3", 32'(byte_valid), 32'd1);
        check("lat_out_t3", 32'(byte_out), 32'h11);
        wait_bytes("scan", base + SCAN_LEN, 1'b0);
        repeat (3) tick();
        expect_scan("scan", base);
        check("scan_done", 32'(done_cnt - d0), 32'd1);

        // frame_valid held high must not retrigger.
        base = got.size();
        byte_ready = 1'b1;
        repeat (20) tick();
        byte_ready = 1'b0;
        check("held_no_bytes", 32'(got.size()), 32'(base));
        check("held_no_done", 32'(done_cnt - d0), 32'd1);
        frame_valid = 1'b0;
        tick();

        // Backpressure on byte 1.
        base = got.size();
        d0   = done_cnt;
        frame_valid = 1'b1;
        wait_valid("bp0");
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        wait_valid("bp1");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(byte_valid), 32'd1);
            check("bp_hold_out", 32'(byte_out), 32'h22);
            tick();
        end
        wait_bytes("bp", base + SCAN_LEN, 1'b0);
        repeat (3) tick();
        frame_valid = 1'b0;
        tick();
        expect_scan("bp", base);
        check("bp_done", 32'(done_cnt - d0), 32'd1);

        // Scan wins over a simultaneous manual request; manual is then dropped.
        base = got.size();
        d0   = done_cnt;
        manual_address = ADDR_W'(3);
        manual_req  = 1'b1;
        frame_valid = 1'b1;
        tick();
        manual_req = 1'b0;
        wait_bytes("prio", base + SCAN_LEN, 1'b0);
        byte_ready = 1'b1;
        repeat (10) tick();
        byte_ready = 1'b0;
        expect_scan("prio", base);
        check("prio_done", 32'(done_cnt - d0), 32'd1);
        frame_valid = 1'b0;
        tick();

        manual_read("man2", 2, 1'b0);
        manual_read("man_oob", 9, 1'b0);
        manual_read("man_oob15", 15, 1'b1);

        // Abort during byte 2.
        base = got.size();
        d0   = done_cnt;
        byte_ready  = 1'b1;
        frame_valid = 1'b1;
        k = 0;
        while (!(byte_valid && mux_address == ADDR_W'(2)) && k < 40) begin
            tick();
            k++;
        end
        check("abort_reach", 32'(byte_valid && mux_address == ADDR_W'(2)), 32'd1);
        byte_ready = 1'b0;
        transmission_begin = 1'b1;
        tick();
        transmission_begin = 1'b0;
        check("abort_valid", 32'(byte_valid), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd1);
        repeat (20) tick();
        check("abort_len", 32'(got.size()), 32'(base + 2));
        check("abort_byte1", 32'(got[base + 1]), 32'(store[1]));
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        frame_valid = 1'b0;
        tick();
        manual_read("post_abort", 1, 1'b0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while presenting.
        frame_valid = 1'b1;
        wait_valid("rstp");
        reset = 1'b1;
        frame_valid = 1'b0;
        tick();
        check("rstp_valid", 32'(byte_valid), 32'd0);
        check("rstp_out", 32'(byte_out), 32'd0);
        check("rstp_addr", 32'(mux_address), 32'd0);
        check("rstp_done", 32'(frame_done), 32'd0);
        check("rstp_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();
        check("rstp_idle", 32'(byte_valid), 32'd0);

        // Randomized store contents and ready patterns.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) store[i] = 8'($urandom);
            run_scan("rand_scan", 1'b1);
            manual_read("rand_man", int'($urandom_range(0, 15)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
